fb_scanout: RTL and testbench
=============================

// Module: fb_scanout
// PURPOSE
//  Read side of the 320x240x8b frame buffer that the rasterizer fills.
//  Generates 640x480@60 VGA timing and fetches one frame-buffer byte per 2x2 screen pixels.
//  Expands RGB332 to 4:4:4 and drives the video encoder.
//  Owns double-buffer selection: the rasterizer draws into !front_sel, and a swap is granted only at vblank start.
// PARAMETERS
//  H_VISIBLE 640 | H_FRONT 16 | H_SYNC 96 | H_BACK 48  : horizontal timing, pixels
//  V_VISIBLE 480 | V_FRONT 10 | V_SYNC 2  | V_BACK 33  : vertical timing, lines
//  FB_WIDTH  320 : frame-buffer row pitch, bytes
// PORTS
//  clk        in   1   pixel clock (25 MHz)
//  rst        in   1   asynchronous reset, active-low
//  fb_en      out  1   frame-buffer read enable
//  fb_addr    out  17  frame-buffer read address (y_fb*320 + x_fb)
//  fb_dout    in   8   frame-buffer read data, RGB332; valid 1 cycle after fb_addr/fb_en
//  front_sel  out  1   buffer being displayed; rasterizer writes the other one
//  swap_req   in   1   one-cycle pulse: back buffer complete, request swap
//  swap_ack   out  1   one-cycle pulse: swap performed
//  vblank     out  1   high while line counter >= V_VISIBLE
//  hsync      out  1   horizontal sync, active-low
//  vsync      out  1   vertical sync, active-low
//  de         out  1   display enable (visible pixel)
//  red        out  4   red channel
//  green      out  4   green channel
//  blue       out  4   blue channel
// BEHAVIOUR
//  Reset (rst=0, async):
//   - hc=vc=0, row_base=0, hsync=vsync=1, de=0, rgb=0, fb_en=0, fb_addr=0.
//   - front_sel=0, swap_ack=0, vblank=0, swap pending cleared.
//   - Reset mid-frame aborts immediately; timing restarts at (0,0) on release.
//  Counters:
//   - hc: 0..799, wraps to 0.
//   - vc: increments when hc==799; 0..524, wraps to 0.
//  Timing stage 0 (combinational from hc,vc):
//   - vis = hc<640 && vc<480.
//   - hs  = !(656<=hc<752).
//   - vs  = !(490<=vc<492).
//  Fetch stage 1 (registered):
//   - fb_en <= vis.
//   - fb_addr <= row_base + hc[9:1].
//   - row_base (17b): += FB_WIDTH at hc==799 when vc[0]==1 && vc<480; cleared at hc==799 && vc==524.
//   - No multiplier on the address path.
//  Output stage 2 (registered):
//   - hs/vs/vis are delayed 2 cycles, so the outputs align with fb_dout.
//   - red={d[7:5],d[7]}, green={d[4:2],d[4]}, blue={d[1:0],d[1:0]}.
//   - rgb is forced to 0 when de=0.
//  Total latency from counter to pins: 2 cycles. Outputs remain sync-aligned with one another.
//  Swap FSM: IDLE -> PENDING on swap_req. PENDING -> IDLE at the cycle after the counter reaches (hc==0, vc==480):
//   - front_sel toggles.
//   - swap_ack=1 for exactly 1 cycle.
//  Swap edge cases:
//   - swap_req in the same cycle the counter reaches (0,480): swap is granted this frame.
//   - swap_req while PENDING: absorbed; at most one swap per frame.
//   - swap_req during vblank after the grant point: granted next frame.
//  vblank: registered; 1 from the cycle after (0,480) through the cycle of (799,524).
// STRUCTURE
//  gpu_pkg:
//   - timing constants, FB_WIDTH/FB_HEIGHT.
//   - typedef logic [7:0] rgb332_t.
//   - typedef struct {logic [3:0] r,g,b;} rgb444_t.
//   - function rgb332_to_444.
//  Sub-module vga_timing_gen: hc/vc counters, hs/vs/vis/vblank-start strobe.
//  fb_scanout holds the fetch, delay pipeline, colour expansion and swap FSM.
// TESTING (BRAM model returns addr[7:0] one cycle late)
//  1 Release rst -> first hsync fall 658 cycles after the first edge (656+2); hsync low 96 cycles; period 800.
//  2 Run one frame -> vsync low 1600 cycles starting at vc=490; frame period 420000 cycles.
//  3 Pixel (x=5,y=3) -> fb_addr=322, data 0x42 -> red=4'b0100, green=4'b0000, blue=4'b1010, de=1.
//  4 swap_req pulse at vc=100 -> swap_ack 1 cycle after (0,480); front_sel 0->1; vblank rises the same cycle.
//  5 Two swap_req pulses in frame n, plus one coincident with (0,480) in frame n+1 -> one toggle per frame.
//  6 Assert rst at hc=300,vc=200 between edges -> outputs take reset values before the next edge; clean restart.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared definitions for the frame-buffer read side.
// Holds the 640x480@60 VGA timing, the frame-buffer geometry, the RGB332
// and 4:4:4 pixel types, and the RGB332 -> 4:4:4 colour expansion.
package gpu_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;

    typedef logic [7:0] rgb332_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Replicate the top bits into the new LSBs so full scale maps to 4'hF.
    function automatic rgb444_t rgb332_to_444(input rgb332_t d);
        rgb444_t c;
        c.r = {d[7:5], d[7]};
        c.g = {d[4:2], d[4]};
        c.b = {d[1:0], d[1:0]};
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters and combinational timing decode.
// Ports:
//   clk, rst        pixel clock, async active-low reset
//   x_half          hc[9:1], horizontal frame-buffer column
//   vis, hs, vs     visible area, active-low h/v sync (stage 0, unregistered)
//   row_step        last pixel of an odd visible line: advance frame-buffer row
//   frame_end       last pixel of the frame
//   vblank_start    counter sits at (0, V_VISIBLE)
module vga_timing_gen
    import gpu_pkg::*;
#(
    parameter int H_VISIBLE = gpu_pkg::H_VISIBLE,
    parameter int H_FRONT   = gpu_pkg::H_FRONT,
    parameter int H_SYNC    = gpu_pkg::H_SYNC,
    parameter int H_BACK    = gpu_pkg::H_BACK,
    parameter int V_VISIBLE = gpu_pkg::V_VISIBLE,
    parameter int V_FRONT   = gpu_pkg::V_FRONT,
    parameter int V_SYNC    = gpu_pkg::V_SYNC,
    parameter int V_BACK    = gpu_pkg::V_BACK
) (
    input  logic       clk,
    input  logic       rst,
    output logic [8:0] x_half,
    output logic       vis,
    output logic       hs,
    output logic       vs,
    output logic       row_step,
    output logic       frame_end,
    output logic       vblank_start
);

    localparam logic [9:0] H_VIS_C = 10'(H_VISIBLE);
    localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS_C = 10'(V_VISIBLE);
    localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    logic [9:0] hc;
    logic [9:0] vc;
    logic       line_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hc <= '0;
            vc <= '0;
        end else if (line_end) begin
            hc <= '0;
            vc <= frame_end ? '0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    assign line_end     = (hc == H_LAST);
    assign frame_end    = line_end && (vc == V_LAST);
    assign x_half       = hc[9:1];
    assign vis          = (hc < H_VIS_C) && (vc < V_VIS_C);
    assign hs           = !((hc >= HS_BEG) && (hc < HS_END));
    assign vs           = !((vc >= VS_BEG) && (vc < VS_END));
    // Each frame-buffer row is shown on two lines; step after the second.
    assign row_step     = line_end && vc[0] && (vc < V_VIS_C);
    assign vblank_start = (hc == 10'd0) && (vc == V_VIS_C);

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: VGA timing, 2x2 pixel fetch, RGB332 expansion and
// double-buffer swap control.
// Ports:
//   clk, rst            pixel clock, async active-low reset
//   fb_en, fb_addr      frame-buffer read request (y_fb*pitch + x_fb)
//   fb_dout             RGB332 read data, one cycle after the request
//   front_sel           buffer on screen; the rasterizer draws the other
//   swap_req, swap_ack  swap request pulse in, grant pulse out
//   vblank              high from vblank start to end of frame
//   hsync, vsync, de    video timing, aligned with red/green/blue
//
// Swap FSM
//   state      | meaning
//   ST_IDLE    | no swap outstanding
//   ST_PENDING | swap requested, waiting for the next vblank start
module fb_scanout
    import gpu_pkg::*;
#(
    parameter int H_VISIBLE = gpu_pkg::H_VISIBLE,
    parameter int H_FRONT   = gpu_pkg::H_FRONT,
    parameter int H_SYNC    = gpu_pkg::H_SYNC,
    parameter int H_BACK    = gpu_pkg::H_BACK,
    parameter int V_VISIBLE = gpu_pkg::V_VISIBLE,
    parameter int V_FRONT   = gpu_pkg::V_FRONT,
    parameter int V_SYNC    = gpu_pkg::V_SYNC,
    parameter int V_BACK    = gpu_pkg::V_BACK,
    parameter int FB_WIDTH  = gpu_pkg::FB_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    output logic        fb_en,
    output logic [16:0] fb_addr,
    input  logic [7:0]  fb_dout,
    output logic        front_sel,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        vblank,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam logic [16:0] ROW_PITCH  = 17'(FB_WIDTH);
    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_PENDING = 1'b1;

    logic [8:0]  x_half;
    logic        vis, hs, vs;
    logic        row_step, frame_end, vblank_start;
    logic [16:0] row_base;
    logic        vis_d, hs_d, vs_d;
    logic [0:0]  state;
    rgb444_t     pix;

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .x_half       (x_half),
        .vis          (vis),
        .hs           (hs),
        .vs           (vs),
        .row_step     (row_step),
        .frame_end    (frame_end),
        .vblank_start (vblank_start)
    );

    // Row base is accumulated so the address path needs only an adder.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_base <= '0;
            fb_en    <= 1'b0;
            fb_addr  <= '0;
            vis_d    <= 1'b0;
            hs_d     <= 1'b1;
            vs_d     <= 1'b1;
        end else begin
            fb_en   <= vis;
            fb_addr <= row_base + {8'd0, x_half};
            vis_d   <= vis;
            hs_d    <= hs;
            vs_d    <= vs;
            if (frame_end) begin
                row_base <= '0;
            end else if (row_step) begin
                row_base <= row_base + ROW_PITCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            de    <= 1'b0;
        end else begin
            hsync <= hs_d;
            vsync <= vs_d;
            de    <= vis_d;
        end
    end

    // The RAM output register is the second pipeline stage for pixel data,
    // so colour is taken straight from fb_dout and gated by the registered de.
    assign pix   = rgb332_to_444(fb_dout);
    assign red   = de ? pix.r : 4'd0;
    assign green = de ? pix.g : 4'd0;
    assign blue  = de ? pix.b : 4'd0;

    // A request arriving on the vblank-start cycle itself is still granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            front_sel <= 1'b0;
            swap_ack  <= 1'b0;
            vblank    <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            if (vblank_start) begin
                vblank <= 1'b1;
            end else if (frame_end) begin
                vblank <= 1'b0;
            end
            if (vblank_start && (state == ST_PENDING || swap_req)) begin
                front_sel <= ~front_sel;
                swap_ack  <= 1'b1;
                state     <= ST_IDLE;
            end else if (swap_req) begin
                state <= ST_PENDING;
            end
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
module tb_fb_scanout;

    // Reduced raster for the model-checked instance so many frames fit.
    localparam int SHV = 40, SHF = 4, SHS = 8, SHB = 4;
    localparam int SVV = 20, SVF = 2, SVS = 2, SVB = 3;
    localparam int SFBW = 20;
    localparam int SHT = SHV + SHF + SHS + SHB;
    localparam int SVT = SVV + SVF + SVS + SVB;
    localparam int SF = SHT * SVT;
    localparam int GRANT_POS = SVV * SHT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic swap_req = 1'b0;
    always #5 clk = ~clk;

    logic        s_fb_en, s_front, s_ack, s_vblank, s_hsync, s_vsync, s_de;
    logic [16:0] s_fb_addr;
    logic [7:0]  s_fb_dout = 8'd0;
    logic [3:0]  s_red, s_green, s_blue;
    logic        d_fb_en, d_front, d_ack, d_vblank, d_hsync, d_vsync, d_de;
    logic [16:0] d_fb_addr;
    logic [7:0]  d_fb_dout = 8'd0;
    logic [3:0]  d_red, d_green, d_blue;

    fb_scanout #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .FB_WIDTH(SFBW)
    ) u_small (
        .clk(clk), .rst(rst), .fb_en(s_fb_en), .fb_addr(s_fb_addr),
        .fb_dout(s_fb_dout), .front_sel(s_front), .swap_req(swap_req),
        .swap_ack(s_ack), .vblank(s_vblank), .hsync(s_hsync), .vsync(s_vsync),
        .de(s_de), .red(s_red), .green(s_green), .blue(s_blue)
    );

    fb_scanout u_full (
        .clk(clk), .rst(rst), .fb_en(d_fb_en), .fb_addr(d_fb_addr),
        .fb_dout(d_fb_dout), .front_sel(d_front), .swap_req(1'b0),
        .swap_ack(d_ack), .vblank(d_vblank), .hsync(d_hsync), .vsync(d_vsync),
        .de(d_de), .red(d_red), .green(d_green), .blue(d_blue)
    );

    // Frame-buffer RAMs: return the low address byte one cycle later.
    always @(posedge clk) begin
        s_fb_dout <= s_fb_addr[7:0];
        d_fb_dout <= d_fb_addr[7:0];
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: t=%0t got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model (small instance) ----------------
    // n = clock edges since reset release; counter position after edge n is n mod SF.
    int n = 0;
    int mp;
    bit m_front = 1'b0;
    bit m_ack = 1'b0;
    bit m_req = 1'b0;
    bit mon_on = 1'b0;

    function automatic int hc_of(input int k); return (k % SF) % SHT; endfunction
    function automatic int vc_of(input int k); return (k % SF) / SHT; endfunction
    function automatic int vis_at(input int k);
        return (hc_of(k) < SHV && vc_of(k) < SVV) ? 1 : 0;
    endfunction
    function automatic int hs_at(input int k);
        return (hc_of(k) >= SHV + SHF && hc_of(k) < SHV + SHF + SHS) ? 0 : 1;
    endfunction
    function automatic int vs_at(input int k);
        return (vc_of(k) >= SVV + SVF && vc_of(k) < SVV + SVF + SVS) ? 0 : 1;
    endfunction
    function automatic int addr_at(input int k);
        int r;
        r = vc_of(k) / 2;
        if (r > SVV / 2) r = SVV / 2;
        return r * SFBW + hc_of(k) / 2;
    endfunction

    // A request outstanding since the last grant point (or arriving on it)
    // is granted when the raster passes vblank start.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            n = 0; m_front = 1'b0; m_ack = 1'b0; m_req = 1'b0;
        end else begin
            mp = n % SF;
            n = n + 1;
            m_ack = 1'b0;
            if (mp == GRANT_POS) begin
                if (m_req || swap_req) begin
                    m_front = !m_front;
                    m_ack = 1'b1;
                end
                m_req = 1'b0;
            end else if (swap_req) begin
                m_req = 1'b1;
            end
        end
    end

    int ede, ed, er, eg, eb;
    always @(negedge clk) begin
        if (mon_on) begin
            check("fb_en", int'(s_fb_en), n >= 1 ? vis_at(n - 1) : 0);
            check("fb_addr", int'(s_fb_addr), n >= 1 ? addr_at(n - 1) : 0);
            check("hsync", int'(s_hsync), n >= 2 ? hs_at(n - 2) : 1);
            check("vsync", int'(s_vsync), n >= 2 ? vs_at(n - 2) : 1);
            ede = n >= 2 ? vis_at(n - 2) : 0;
            check("de", int'(s_de), ede);
            ed = n >= 2 ? addr_at(n - 2) % 256 : 0;
            er = 0; eg = 0; eb = 0;
            if (ede != 0) begin
                er = (ed / 32) * 2 + ed / 128;
                eg = ((ed / 4) % 8) * 2 + ((ed / 4) % 8) / 4;
                eb = (ed % 4) * 5;
            end
            check("red", int'(s_red), er);
            check("green", int'(s_green), eg);
            check("blue", int'(s_blue), eb);
            check("vblank", int'(s_vblank), ((n % SF) > GRANT_POS) ? 1 : 0);
            check("front_sel", int'(s_front), int'(m_front));
            check("swap_ack", int'(s_ack), int'(m_ack));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_pos(input int pos);
        for (int i = 0; i < SF + 2 && (n % SF) != pos; i++) @(negedge clk);
        check("wait_pos", n % SF, pos);
    endtask

    task automatic pulse_at(input int pos);
        wait_pos(pos);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_fb_en", int'(s_fb_en) + int'(d_fb_en), 0);
        check("rst_fb_addr", int'(s_fb_addr) + int'(d_fb_addr), 0);
        check("rst_sync", int'(s_hsync) + int'(s_vsync) + int'(d_hsync) + int'(d_vsync), 4);
        check("rst_de_rgb", int'(s_de) + int'(d_de) + int'(s_red) + int'(s_green) + int'(s_blue)
              + int'(d_red) + int'(d_green) + int'(d_blue), 0);
        check("rst_swap", int'(s_front) + int'(s_ack) + int'(s_vblank)
              + int'(d_front) + int'(d_ack) + int'(d_vblank), 0);
    endtask

    int d_fall1, d_fall2, d_rise1, s_hfall, s_vfall, s_vrise, s_vbrise;
    bit pd_h, ps_h, ps_v, ps_vb;

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals();
        mon_on = 1'b1;
        rst = 1'b1;

        // Timing of the full-size instance and first-frame landmarks of the small one.
        d_fall1 = -1; d_fall2 = -1; d_rise1 = -1;
        s_hfall = -1; s_vfall = -1; s_vrise = -1; s_vbrise = -1;
        pd_h = 1'b1; ps_h = 1'b1; ps_v = 1'b1; ps_vb = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (pd_h && !d_hsync) begin
                if (d_fall1 < 0) d_fall1 = n;
                else if (d_fall2 < 0) d_fall2 = n;
            end
            if (!pd_h && d_hsync && d_rise1 < 0) d_rise1 = n;
            if (ps_h && !s_hsync && s_hfall < 0) s_hfall = n;
            if (ps_v && !s_vsync && s_vfall < 0) s_vfall = n;
            if (!ps_v && s_vsync && s_vrise < 0) s_vrise = n;
            if (!ps_vb && s_vblank && s_vbrise < 0) s_vbrise = n;
            pd_h = d_hsync; ps_h = s_hsync; ps_v = s_vsync; ps_vb = s_vblank;
            if (n == 2406) begin
                check("pix_addr", int'(d_fb_addr), 322);
                check("pix_en", int'(d_fb_en), 1);
            end
            if (n == 2407) begin
                check("pix_red", int'(d_red), 4);
                check("pix_green", int'(d_green), 0);
                check("pix_blue", int'(d_blue), 10);
                check("pix_de", int'(d_de), 1);
            end
            if (n == 3 * SHT + 5 + 1) check("small_pix_addr", int'(s_fb_addr), 22);
        end
        check("hsync_first_fall", d_fall1, 658);
        check("hsync_low_len", d_rise1 - d_fall1, 96);
        check("hsync_period", d_fall2 - d_fall1, 800);
        check("small_hsync_fall", s_hfall, 46);
        check("small_vsync_fall", s_vfall, 1234);
        check("small_vsync_len", s_vrise - s_vfall, 112);
        check("small_vblank_rise", s_vbrise, 1121);

        // Single request mid-frame.
        pulse_at(100);
        wait_pos(GRANT_POS + 1);
        check("grant_ack", int'(s_ack), 1);
        check("grant_front", int'(s_front), 1);
        check("grant_vblank", int'(s_vblank), 1);
        @(negedge clk);
        check("grant_ack_len", int'(s_ack), 0);

        // Two requests in one frame, then one on the grant cycle of the next.
        pulse_at(200);
        pulse_at(500);
        wait_pos(GRANT_POS + 1);
        check("double_req_front", int'(s_front), 0);
        pulse_at(GRANT_POS);
        check("coincident_front", int'(s_front), 1);

        // Request after the grant point waits a whole frame.
        pulse_at(GRANT_POS + 80);
        wait_pos(GRANT_POS);
        check("late_req_held", int'(s_front), 1);
        wait_pos(GRANT_POS + 1);
        check("late_req_front", int'(s_front), 0);

        // Random request traffic.
        for (int i = 0; i < 15 * SF; i++) begin
            @(negedge clk);
            swap_req = ($urandom_range(0, 999) == 0);
        end
        swap_req = 1'b0;

        // Asynchronous reset mid-frame, between clock edges.
        wait_pos(12 * SHT + 30);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_vals();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        pulse_at(50);
        wait_pos(GRANT_POS + 1);
        check("restart_front", int'(s_front), 1);
        for (int i = 0; i < SF; i++) begin
            @(negedge clk);
            swap_req = ($urandom_range(0, 499) == 0);
        end
        swap_req = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
